// File: rtl/sync_ram_ctrl.sv
// Single-port sync RAM initiator: one valid/ready request in, one response pulse out.
// The RAM pins are decoded from the registered state only, so req_* never reach mem_* combinationally.
module sync_ram_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_SETUP = 2'd2,
    RD_DATA  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_e                state_q, state_d;
  req_t                  lat_q, lat_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  drive_en;

  // State, latched request and response registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state: accept in IDLE, write is one cycle, read is setup then data.
  // The response is registered, so the pulse lands in the IDLE cycle that follows.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lat_d.we    = req_we;
          lat_d.addr  = req_addr;
          lat_d.wdata = req_wdata;
          state_d     = req_we ? WRITE : RD_SETUP;
        end
      end
      WRITE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_write_d = lat_q.we;
      end
      RD_SETUP: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        // RAM has been driving its output register since this cycle began.
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_write_d = lat_q.we;
        rsp_rdata_d = mem_data;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore pin decode; mem_addr simply shows the last latched address.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_cs    = (state_q != IDLE);
    mem_we    = (state_q == WRITE);
    mem_oe    = (state_q == RD_DATA);
    drive_en  = (state_q == WRITE);
    mem_addr  = lat_q.addr;
  end

  // Bus is owned only in WRITE, which is disjoint from the RAM's oe window.
  assign mem_data  = drive_en ? lat_q.wdata : {DATA_WIDTH{1'bz}};

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

  a_no_we_oe: assert property (@(posedge clk) disable iff (!rst_n) !(mem_we && mem_oe));
  a_rsp_pulse: assert property (@(posedge clk) disable iff (!rst_n) rsp_valid |=> !rsp_valid);

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Scoreboard bench for sync_ram_ctrl with a behavioural single-port sync RAM on mem_*.
module tb_sync_ram_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs, mem_we, mem_oe;

  sync_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: write on cs&we, otherwise load output register on cs; drive bus when oe.
  logic [DW-1:0] ram [16];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_data;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : {DW{1'bz}};

  typedef struct {
    bit            wr;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_rd = '0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: bus rules every cycle, and pop/compare on every response pulse.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ((mem_we && mem_oe) || (req_ready && (mem_cs || mem_we || mem_oe)) ||
        (mem_oe && (mem_data !== ram_q))) begin
      errors++;
      $display("FAIL bus: cs=%b we=%b oe=%b ready=%b data=%0h ram_q=%0h (cycle %0d)",
               mem_cs, mem_we, mem_oe, req_ready, mem_data, ram_q, cyc);
    end
    if (rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("rsp_write", rsp_write, e.wr);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one request; push the expected response; return the accept-edge cycle.
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit hold, output int acc);
    exp_t e;
    int   t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc  = cyc + 1;
    e.wr = we;
    if (we) begin
      ref_mem[a] = d;
      e.rdata    = last_rd;
      e.cyc      = acc + 1;
    end else begin
      e.rdata = ref_mem[a];
      last_rd = ref_mem[a];
      e.cyc   = acc + 2;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    for (int i = 0; i < 16; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {mem_cs, mem_we, mem_oe, rsp_valid, rsp_write}, 5'b0);
    chk("rst_addr", mem_addr, 4'h0);
    chk("rst_ready", req_ready, 1'b1);
    rst_n = 1'b1;

    // Idle for 10 cycles: nothing moves
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctrl", {mem_cs, mem_we, mem_oe, rsp_valid}, 4'b0);
      chk("idle_rdata", rsp_rdata, 32'h0);
    end

    // Write then read same address
    issue(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, a0);
    drain();
    issue(1'b0, 4'd3, 32'h0, 1'b0, a0);
    drain();

    // Back-to-back writes with req_valid held: one accept per 2 cycles
    issue(1'b1, 4'd0, 32'h11111111, 1'b1, a0);
    issue(1'b1, 4'd1, 32'h22222222, 1'b1, a1);
    issue(1'b1, 4'd15, 32'h33333333, 1'b0, a2);
    chk("b2b_gap01", a1 - a0, 2);
    chk("b2b_gap12", a2 - a1, 2);
    drain();
    issue(1'b0, 4'd0, 32'h0, 1'b0, a0);
    issue(1'b0, 4'd1, 32'h0, 1'b0, a1);
    issue(1'b0, 4'd15, 32'h0, 1'b0, a2);
    chk("rd_gap", a2 - a1, 3);
    drain();

    // Read accepted in the write's response cycle, then write must not touch rsp_rdata
    issue(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, a0);
    issue(1'b0, 4'd7, 32'h0, 1'b0, a1);
    chk("raw_gap", a1 - a0, 2);
    issue(1'b1, 4'd7, 32'h0, 1'b0, a2);
    drain();

    // Reset in the middle of RD_DATA
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rd_data_oe", {mem_cs, mem_oe}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {mem_cs, mem_oe, rsp_valid}, 3'b0);
    chk("async_rst_ready", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    last_rd = '0;
    @(negedge clk);
    chk("post_rst_rdata", rsp_rdata, 32'h0);
    chk("post_rst_ready", req_ready, 1'b1);
    issue(1'b0, 4'd3, 32'h0, 1'b0, a0);
    issue(1'b0, 4'd0, 32'h0, 1'b0, a1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
